// File: rtl/mem_wb_pipe_pkg.sv
// Shared definitions for the MEM/WB pipeline register: writeback select
// encodings (mux input order), datapath defaults and the retirement FSM states.
package mem_wb_pipe_pkg;

  localparam int unsigned WIDTH_DEF      = 16;
  localparam int unsigned REG_ADDR_W_DEF = 3;

  // Writeback mux select, in mux input order A..D
  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC2 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  // Retirement state: HALTED is sticky until reset
  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

endpackage

// File: rtl/mem_wb_pipe_dff_en_rn.sv
// Parameterised-width register with load enable and asynchronous
// active-low reset to zero.
module dff_en_rn #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;

  // Load on enable, clear immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (en) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register feeding the writeback 4:1 result mux and the
// register file. Supports stall, flush (flush wins) and HALT retirement:
// once HALT is captured nothing further retires until reset.
// Optional macro MEM_WB_RETIRE_CNT_EN adds a 16-bit wrapping retire counter.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_alu,
  input  logic [WIDTH-1:0]      in_mem,
  input  logic [WIDTH-1:0]      in_pc2,
  input  logic [WIDTH-1:0]      in_imm,
  input  logic [1:0]            in_wb_sel,
  input  logic                  in_reg_we,
  input  logic [REG_ADDR_W-1:0] in_wr_reg,
  input  logic                  in_halt,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  wb_valid,
  output logic [WIDTH-1:0]      wb_alu,
  output logic [WIDTH-1:0]      wb_mem,
  output logic [WIDTH-1:0]      wb_pc2,
  output logic [WIDTH-1:0]      wb_imm,
  output logic [1:0]            wb_sel,
  output logic                  wb_reg_we,
  output logic [REG_ADDR_W-1:0] wb_wr_reg,
  output logic                  halted
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  output logic [15:0]           retire_cnt
`endif
);

  state_e                state_q, state_d;
  logic                  capture;
  logic                  valid_d, valid_q;
  logic                  we_d, we_q;
  logic [WIDTH-1:0]      alu_q, mem_q, pc2_q, imm_q;
  logic [1:0]            sel_q;
  logic [REG_ADDR_W-1:0] wr_reg_q;

  // Retirement state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and control: flush beats stall beats capture; HALTED drains
  // the HALT instruction's valid after one cycle and then ignores everything.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    valid_d = valid_q;
    we_d    = we_q;
    case (state_q)
      RUN: begin
        if (flush) begin
          valid_d = 1'b0;
          we_d    = 1'b0;
        end else if (!stall) begin
          capture = 1'b1;
          valid_d = in_valid;
          we_d    = in_valid & in_reg_we;
          if (in_valid && in_halt) begin
            state_d = HALTED;
          end
        end
      end
      HALTED: begin
        valid_d = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // Control flops update every edge (hold/flush handled in valid_d/we_d);
  // data fields load only on capture so flush leaves them intact.
  dff_en_rn #(.WIDTH(1)) u_valid (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .d(valid_d), .q(valid_q)
  );
  dff_en_rn #(.WIDTH(1)) u_we (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .d(we_d), .q(we_q)
  );
  dff_en_rn #(.WIDTH(WIDTH)) u_alu (
    .clk(clk), .rst_n(rst_n), .en(capture), .d(in_alu), .q(alu_q)
  );
  dff_en_rn #(.WIDTH(WIDTH)) u_mem (
    .clk(clk), .rst_n(rst_n), .en(capture), .d(in_mem), .q(mem_q)
  );
  dff_en_rn #(.WIDTH(WIDTH)) u_pc2 (
    .clk(clk), .rst_n(rst_n), .en(capture), .d(in_pc2), .q(pc2_q)
  );
  dff_en_rn #(.WIDTH(WIDTH)) u_imm (
    .clk(clk), .rst_n(rst_n), .en(capture), .d(in_imm), .q(imm_q)
  );
  dff_en_rn #(.WIDTH(2)) u_sel (
    .clk(clk), .rst_n(rst_n), .en(capture), .d(in_wb_sel), .q(sel_q)
  );
  dff_en_rn #(.WIDTH(REG_ADDR_W)) u_wr_reg (
    .clk(clk), .rst_n(rst_n), .en(capture), .d(in_wr_reg), .q(wr_reg_q)
  );

  assign wb_valid  = valid_q;
  assign wb_reg_we = we_q;
  assign wb_alu    = alu_q;
  assign wb_mem    = mem_q;
  assign wb_pc2    = pc2_q;
  assign wb_imm    = imm_q;
  assign wb_sel    = sel_q;
  assign wb_wr_reg = wr_reg_q;
  assign halted    = (state_q == HALTED);

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Count every capture that leaves a valid instruction in the register
  always_comb begin
    cnt_d = cnt_q;
    if (capture && in_valid) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Retire counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retire_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: table-driven vectors with a scoreboard
// queue, plus hand sequences for async reset, HALT under stall and the
// optional retire counter (MEM_WB_RETIRE_CNT_EN).
module tb_mem_wb_pipe;
  import mem_wb_pipe_pkg::*;

  typedef struct {
    logic        v;
    logic [15:0] alu, mem, pc2, imm;
    logic [1:0]  sel;
    logic        we;
    logic [2:0]  wr;
    logic        hlt;
  } exp_t;

  typedef struct {
    logic        v;
    logic [15:0] alu, mem, pc2, imm;
    logic [1:0]  sel;
    logic        we;
    logic [2:0]  wr;
    logic        halt, stall, flush;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_reg_we, in_halt, stall, flush;
  logic [15:0] in_alu, in_mem, in_pc2, in_imm;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_wr_reg;
  logic        wb_valid, wb_reg_we, halted;
  logic [15:0] wb_alu, wb_mem, wb_pc2, wb_imm;
  logic [1:0]  wb_sel;
  logic [2:0]  wb_wr_reg;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  exp_t        sb_q[$];
  vec_t        vecs[13];

  always #5 clk = ~clk;

  mem_wb_pipe #(.WIDTH(16), .REG_ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_alu(in_alu), .in_mem(in_mem), .in_pc2(in_pc2), .in_imm(in_imm),
    .in_wb_sel(in_wb_sel), .in_reg_we(in_reg_we), .in_wr_reg(in_wr_reg),
    .in_halt(in_halt), .stall(stall), .flush(flush),
    .wb_valid(wb_valid), .wb_alu(wb_alu), .wb_mem(wb_mem), .wb_pc2(wb_pc2),
    .wb_imm(wb_imm), .wb_sel(wb_sel), .wb_reg_we(wb_reg_we),
    .wb_wr_reg(wb_wr_reg), .halted(halted)
`ifdef MEM_WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mke(input logic v, input logic [15:0] alu, mem, pc2, imm,
                               input logic [1:0] sel, input logic we,
                               input logic [2:0] wr, input logic hlt);
    exp_t e;
    e.v = v; e.alu = alu; e.mem = mem; e.pc2 = pc2; e.imm = imm;
    e.sel = sel; e.we = we; e.wr = wr; e.hlt = hlt;
    return e;
  endfunction

  function automatic vec_t mk(input logic v, input logic [15:0] alu, mem, pc2, imm,
                              input logic [1:0] sel, input logic we, input logic [2:0] wr,
                              input logic halt, stl, fl, input exp_t e);
    vec_t x;
    x.v = v; x.alu = alu; x.mem = mem; x.pc2 = pc2; x.imm = imm;
    x.sel = sel; x.we = we; x.wr = wr;
    x.halt = halt; x.stall = stl; x.flush = fl; x.e = e;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, ".wb_valid"},  32'(wb_valid),  32'(e.v));
    chk({tag, ".wb_alu"},    32'(wb_alu),    32'(e.alu));
    chk({tag, ".wb_mem"},    32'(wb_mem),    32'(e.mem));
    chk({tag, ".wb_pc2"},    32'(wb_pc2),    32'(e.pc2));
    chk({tag, ".wb_imm"},    32'(wb_imm),    32'(e.imm));
    chk({tag, ".wb_sel"},    32'(wb_sel),    32'(e.sel));
    chk({tag, ".wb_reg_we"}, 32'(wb_reg_we), 32'(e.we));
    chk({tag, ".wb_wr_reg"}, 32'(wb_wr_reg), 32'(e.wr));
    chk({tag, ".halted"},    32'(halted),    32'(e.hlt));
  endtask

  task automatic drive(input vec_t x);
    in_valid = x.v; in_alu = x.alu; in_mem = x.mem; in_pc2 = x.pc2; in_imm = x.imm;
    in_wb_sel = x.sel; in_reg_we = x.we; in_wr_reg = x.wr;
    in_halt = x.halt; stall = x.stall; flush = x.flush;
  endtask

  // Drive one vector, queue its expectation, compare after the edge
  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s.scoreboard: got empty expected entry", tag);
    end else begin
      e = sb_q.pop_front();
      check_out(tag, e);
    end
  endtask

  task automatic apply(input string tag, input vec_t x);
    @(negedge clk);
    drive(x);
    sb_q.push_back(x.e);
    step(tag);
  endtask

`ifdef MEM_WB_RETIRE_CNT_EN
  task automatic cyc(input logic v, input logic stl, input logic fl, input logic h);
    @(negedge clk);
    in_valid = v; stall = stl; flush = fl; in_halt = h; in_reg_we = 1'b1;
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    exp_t e0, e4, e5, e6, e9, ez;
    vec_t z;

    ez = mke(0, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 0, 3'd0, 0);
    e0 = mke(1, 16'h1234, 16'h0, 16'h0, 16'h0, WB_ALU, 1, 3'd3, 0);
    e4 = mke(1, 16'h7777, 16'h1111, 16'h2222, 16'h3333, WB_PC2, 1, 3'd5, 0);
    e5 = mke(1, 16'h0, 16'hBEEF, 16'h0, 16'h0, WB_MEM, 1, 3'd2, 0);
    e6 = mke(0, 16'h0, 16'hBEEF, 16'h0, 16'h0, WB_MEM, 0, 3'd2, 0);
    e9 = mke(1, 16'h0, 16'h5A5A, 16'h0102, 16'h0, WB_ALU, 0, 3'd0, 1);

    vecs[0]  = mk(1, 16'h1234, 16'h0, 16'h0, 16'h0, WB_ALU, 1, 3'd3, 0, 0, 0, e0);
    vecs[1]  = mk(1, 16'h5555, 16'h1111, 16'h0, 16'h0, WB_MEM, 1, 3'd5, 0, 1, 0, e0);
    vecs[2]  = mk(1, 16'h6666, 16'h1111, 16'h0, 16'h0, WB_MEM, 1, 3'd5, 0, 1, 0, e0);
    vecs[3]  = mk(1, 16'h7777, 16'h1111, 16'h2222, 16'h3333, WB_PC2, 1, 3'd5, 0, 1, 0, e0);
    vecs[4]  = mk(1, 16'h7777, 16'h1111, 16'h2222, 16'h3333, WB_PC2, 1, 3'd5, 0, 0, 0, e4);
    vecs[5]  = mk(1, 16'h0, 16'hBEEF, 16'h0, 16'h0, WB_MEM, 1, 3'd2, 0, 0, 0, e5);
    vecs[6]  = mk(1, 16'hAAAA, 16'hCCCC, 16'h1, 16'h1, WB_IMM, 1, 3'd6, 0, 1, 1, e6);
    vecs[7]  = mk(1, 16'hAAAA, 16'hCCCC, 16'h1, 16'h1, WB_IMM, 1, 3'd6, 0, 0, 1, e6);
    vecs[8]  = mk(0, 16'h0F0F, 16'h0, 16'h0, 16'h4444, WB_IMM, 1, 3'd7, 0, 0, 0,
                  mke(0, 16'h0F0F, 16'h0, 16'h0, 16'h4444, WB_IMM, 0, 3'd7, 0));
    vecs[9]  = mk(1, 16'h0, 16'h5A5A, 16'h0102, 16'h0, WB_ALU, 0, 3'd0, 1, 0, 0, e9);
    vecs[10] = mk(1, 16'h9999, 16'h1, 16'h1, 16'h1, WB_MEM, 1, 3'd4, 0, 0, 0,
                  mke(0, 16'h0, 16'h5A5A, 16'h0102, 16'h0, WB_ALU, 0, 3'd0, 1));
    vecs[11] = mk(1, 16'h9999, 16'h1, 16'h1, 16'h1, WB_MEM, 1, 3'd4, 0, 1, 1, vecs[10].e);
    vecs[12] = mk(1, 16'h8888, 16'h2, 16'h2, 16'h2, WB_PC2, 1, 3'd1, 1, 0, 0, vecs[10].e);

    z = mk(0, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 0, 3'd0, 0, 0, 0, ez);
    rst_n = 1'b0;
    drive(z);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", ez);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Async reset while HALTED and stalled, between clock edges
    @(negedge clk);
    stall = 1'b1;
    #2;
    chk("pre_async.halted", 32'(halted), 32'd1);
    rst_n = 1'b0;
    #1;
    check_out("async_rst", ez);
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_rst", vecs[0]);

    // HALT presented during stall is not taken until the stall releases
    apply("halt_stalled", mk(1, 16'h4321, 16'h0, 16'h0, 16'h0, WB_ALU, 0, 3'd1, 1, 1, 0, e0));
    apply("halt_release", mk(1, 16'h4321, 16'h0, 16'h0, 16'h0, WB_ALU, 0, 3'd1, 1, 0, 0,
                             mke(1, 16'h4321, 16'h0, 16'h0, 16'h0, WB_ALU, 0, 3'd1, 1)));
    apply("halt_drain", mk(1, 16'h1, 16'h1, 16'h1, 16'h1, WB_IMM, 1, 3'd2, 0, 0, 0,
                           mke(0, 16'h4321, 16'h0, 16'h0, 16'h0, WB_ALU, 0, 3'd1, 1)));

`ifdef MEM_WB_RETIRE_CNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    drive(z);
    #1;
    chk("cnt.reset", 32'(retire_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("cnt.five", 32'(retire_cnt), 32'd5);
    for (int i = 0; i < 65530; i++) cyc(1, 0, 0, 0);
    chk("cnt.ffff", 32'(retire_cnt), 32'hFFFF);
    cyc(1, 0, 0, 0);
    chk("cnt.wrap", 32'(retire_cnt), 32'h0000);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("cnt.frozen", 32'(retire_cnt), 32'd1);
`endif

    chk("scoreboard.drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Pipeline register between the memory stage and the writeback 4:1 result mux. The mux selects between ALU result, load data, PC+2 and immediate.
- Captures the four candidate 16-bit results, the 2-bit writeback select and register-write control. Presents them stably to the mux and the register file for one writeback cycle.
- Handles stall and flush.
- Tracks HALT retirement with a small state machine so nothing retires after HALT.

Parameters:
- WIDTH, 16, datapath width of every candidate result.
- REG_ADDR_W, 3, destination register address width (8 GPRs).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  memory stage holds a real instruction.
- in_alu  in  WIDTH  ALU result (mux input A).
- in_mem  in  WIDTH  load data (mux input B).
- in_pc2  in  WIDTH  PC+2 for JAL/JALR link (mux input C).
- in_imm  in  WIDTH  immediate for LBI/SLBI (mux input D).
- in_wb_sel  in  2  writeback select, encoded per package.
- in_reg_we  in  1  instruction writes the register file.
- in_wr_reg  in  REG_ADDR_W  destination register.
- in_halt  in  1  instruction is HALT.
- stall  in  1  hold all state (e.g. memory not done).
- flush  in  1  kill the held instruction.
- wb_valid  out  1  held instruction valid.
- wb_alu, wb_mem, wb_pc2, wb_imm  out  WIDTH each  registered candidates to the mux.
- wb_sel  out  2  registered mux select.
- wb_reg_we  out  1  register-file write enable, qualified.
- wb_wr_reg  out  REG_ADDR_W  registered destination.
- halted  out  1  HALT has retired.

Behaviour:
- Reset (rst_n=0, async): all outputs go to 0; state = RUN.
- States: RUN, HALTED.
- Per rising edge in RUN, first matching rule wins:
  1. flush=1: wb_valid<=0, wb_reg_we<=0; data/sel/wr_reg hold their old values.
  2. stall=1: every register holds.
  3. Otherwise: capture all inputs.
     - wb_valid<=in_valid.
     - wb_reg_we<=in_valid & in_reg_we.
     - If in_valid & in_halt: state<=HALTED.
- Flush and stall together: flush wins.
- Latency: exactly 1 cycle from input to output; no bypass path.
- wb_reg_we is never 1 while wb_valid=0.
- Entering HALTED: the HALT instruction's own outputs are visible for one cycle (wb_valid=1, wb_reg_we=0 by decode).
  - halted=1 from the same edge that captures HALT.
- In HALTED: on the next edge, wb_valid<=0 and wb_reg_we<=0. Afterwards inputs, stall and flush are ignored; data holds; halted stays 1 until reset.
- HALT captured while stall=1 is not captured; it stays upstream until the stall releases.
- Reset asserted mid-stall or in HALTED: immediate clear to the reset values.
- No arithmetic; widths pass through unchanged.

Optional Feature:
- Macro: MEM_WB_RETIRE_CNT_EN.
- Defined: adds output retire_cnt, 16-bit. It resets to 0 and increments on each edge where wb_valid is 1 after that edge (a capture with in_valid=1, not stalled, not flushed, state RUN). It wraps 0xFFFF->0x0000 and freezes in HALTED.
- Undefined: no port and no counter logic; behaviour is otherwise identical.

Decomposition:
- Shared package holds the WB_SEL encodings, matching mux input order: WB_ALU=2'b00, WB_MEM=2'b01, WB_PC2=2'b10, WB_IMM=2'b11. It also holds WIDTH/REG_ADDR_W defaults and the state encoding RUN=1'b0, HALTED=1'b1.
- Natural sub-module: dff_en_rn, a parameterised-width register with enable and async active-low reset. Instantiate it per field; control logic lives in the top.

Test Plan:
- Reset, then in_valid=1, in_alu=16'h1234, in_wb_sel=WB_ALU, in_reg_we=1, in_wr_reg=3 -> next cycle wb_valid=1, wb_alu=16'h1234, wb_sel=2'b00, wb_reg_we=1, wb_wr_reg=3.
- Hold capture, then stall=1 for 3 cycles with changing inputs -> outputs unchanged all 3 cycles; stall=0 -> the new inputs appear one cycle later.
- Captured valid load (in_mem=16'hBEEF, wb_sel=WB_MEM), then flush=1 and stall=1 together -> wb_valid=0, wb_reg_we=0, wb_mem still 16'hBEEF.
- in_valid=1, in_reg_we=0, in_halt=1 -> halted=1 and wb_valid=1 for one cycle. Next cycle wb_valid=0. Further valid inputs (in_reg_we=1) never raise wb_reg_we; halted stays 1.
- Drop rst_n asynchronously mid-cycle while HALTED and stalled -> all outputs 0 immediately, without a clock edge; after release, normal capture resumes.
- With MEM_WB_RETIRE_CNT_EN: 5 valid captures, 1 flushed, 2 stalled cycles -> retire_cnt=5. Preload near wrap: 0xFFFF plus one retire -> 0x0000.
